// File: rtl/spi_sd_pkg.sv
// Shared types and constants for the SPI microSD responder.
// SPI_SD_CRC7_EN enables CRC7 checking of received command frames.
package spi_sd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam logic [1:0] SD_START_MASK = 2'b01;
   localparam logic [7:0] SD_FILL       = 8'hFF;
   localparam logic [7:0] SD_R1_CRC_ERR = 8'h08;
   localparam logic [6:0] CRC7_POLY     = 7'h09;

endpackage

// File: rtl/spi_sd_crc7.sv
// Serial CRC7 engine (x^7 + x^3 + 1), MSB-first bit stream.
// Used by spi_sd_responder only when SPI_SD_CRC7_EN is defined.
import spi_sd_pkg::*;

module spi_sd_crc7 (
   input  logic       spi_clk_i,
   input  logic       spi_rst_i,
   input  logic       clear,
   input  logic       bit_valid,
   input  logic       bit_in,
   output logic [6:0] crc
);

   logic fb;

   assign fb = bit_in ^ crc[6];

   always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
      if (spi_rst_i) begin
         crc <= '0;
      end else if (clear) begin
         crc <= '0;
      end else if (bit_valid) begin
         crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
      end
   end

endmodule

// File: rtl/spi_sd_responder.sv
// SPI mode-0 microSD command-layer target: frames commands, returns R1.
// Define SPI_SD_CRC7_EN to check CRC7 and auto-answer bad frames.
import spi_sd_pkg::*;

module spi_sd_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int NCR_MIN     = 1,
   parameter int NCR_MAX     = 8
) (
   input  logic        spi_clk_i,
   input  logic        spi_rst_i,
   input  logic        SCK_i,
   input  logic        MOSI_i,
   input  logic        SS_i,
   output logic        MISO_o,
   output logic        miso_oe_o,
   output logic [47:0] cmd_o,
   output logic        cmd_valid_o,
   input  logic [7:0]  r1_i,
   input  logic        r1_valid_i,
   output logic        busy_o,
   output logic        timeout_o,
   output logic        crc_err_o
);

   localparam int FW = $clog2(NCR_MAX + 1);

   logic [SYNC_STAGES-1:0] sck_q, mosi_q, ss_q;
   logic          sck_s, mosi_s, ss_s, sck_prev;
   logic          rise, fall, boundary;
   state_t        state;
   logic [2:0]    bit_cnt, byte_cnt;
   logic [FW-1:0] fill_cnt, fill_inc;
   logic [6:0]    rx_sr;
   logic [7:0]    rx_byte, tx_sr, tx_nxt, r1_byte, r1_val;
   logic [39:0]   frame;
   logic          load_pend, r1_have, have_r1, crc_ok;

   always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
      if (spi_rst_i) begin
         sck_q    <= '0;
         mosi_q   <= '1;
         ss_q     <= '1;
         sck_prev <= 1'b0;
      end else begin
         sck_q[0]  <= SCK_i;
         mosi_q[0] <= MOSI_i;
         ss_q[0]   <= SS_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sck_q[i]  <= sck_q[i-1];
            mosi_q[i] <= mosi_q[i-1];
            ss_q[i]   <= ss_q[i-1];
         end
         sck_prev <= sck_s;
      end
   end

   assign sck_s    = sck_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_q[SYNC_STAGES-1];
   assign ss_s     = ss_q[SYNC_STAGES-1];
   assign rise     = sck_s & ~sck_prev & ~ss_s;
   assign fall     = ~sck_s & sck_prev & ~ss_s;
   assign boundary = rise && (bit_cnt == 3'd7);
   assign rx_byte  = {rx_sr, mosi_s};
   assign busy_o   = (state != ST_IDLE);
   assign have_r1  = r1_have | r1_valid_i;
   assign r1_val   = r1_have ? r1_byte : r1_i;
   assign fill_inc = (fill_cnt == FW'(NCR_MAX)) ? fill_cnt
                                                : fill_cnt + 1'b1;

`ifdef SPI_SD_CRC7_EN
   logic [6:0] crc;
   logic       crc_clr, crc_bit;

   // Byte0 is accumulated speculatively in IDLE and dropped if not a start byte.
   assign crc_clr = ss_s || state == ST_WAIT || state == ST_RESP
                 || (boundary && state == ST_IDLE
                     && rx_byte[7:6] != SD_START_MASK);
   assign crc_bit = rise && (state == ST_IDLE
                 || (state == ST_CMD && byte_cnt != 3'd5));
   assign crc_ok  = (crc == rx_byte[7:1]);

   spi_sd_crc7 u_crc7 (
      .spi_clk_i (spi_clk_i),
      .spi_rst_i (spi_rst_i),
      .clear     (crc_clr),
      .bit_valid (crc_bit),
      .bit_in    (mosi_s),
      .crc       (crc)
   );
`else
   assign crc_ok    = 1'b1;
   assign crc_err_o = 1'b0;
`endif

   always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
      if (spi_rst_i) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         byte_cnt    <= '0;
         fill_cnt    <= '0;
         rx_sr       <= '1;
         tx_sr       <= SD_FILL;
         tx_nxt      <= SD_FILL;
         frame       <= '1;
         load_pend   <= 1'b0;
         r1_have     <= 1'b0;
         r1_byte     <= '0;
         MISO_o      <= 1'b1;
         miso_oe_o   <= 1'b0;
         cmd_o       <= '0;
         cmd_valid_o <= 1'b0;
         timeout_o   <= 1'b0;
`ifdef SPI_SD_CRC7_EN
         crc_err_o   <= 1'b0;
`endif
      end else begin
         cmd_valid_o <= 1'b0;
         timeout_o   <= 1'b0;
`ifdef SPI_SD_CRC7_EN
         crc_err_o   <= 1'b0;
`endif
         miso_oe_o   <= ~ss_s;
         if (ss_s) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            fill_cnt  <= '0;
            rx_sr     <= '1;
            tx_sr     <= SD_FILL;
            load_pend <= 1'b0;
            r1_have   <= 1'b0;
            MISO_o    <= 1'b1;
         end else begin
            if (state == ST_WAIT && r1_valid_i && !r1_have) begin
               r1_have <= 1'b1;
               r1_byte <= r1_i;
            end
            if (fall) begin
               if (load_pend) begin
                  MISO_o    <= tx_nxt[7];
                  tx_sr     <= {tx_nxt[6:0], 1'b1};
                  load_pend <= 1'b0;
               end else begin
                  MISO_o <= tx_sr[7];
                  tx_sr  <= {tx_sr[6:0], 1'b1};
               end
            end
            if (rise) begin
               rx_sr   <= rx_byte[6:0];
               bit_cnt <= bit_cnt + 3'd1;
            end
            if (boundary) begin
               load_pend <= 1'b1;
               tx_nxt    <= SD_FILL;
               frame     <= {frame[31:0], rx_byte};
               unique case (state)
                  ST_IDLE: begin
                     if (rx_byte[7:6] == SD_START_MASK) begin
                        state    <= ST_CMD;
                        byte_cnt <= 3'd1;
                     end
                  end
                  ST_CMD: begin
                     if (byte_cnt == 3'd5) begin
                        state    <= ST_WAIT;
                        byte_cnt <= '0;
                        fill_cnt <= '0;
                        r1_have  <= 1'b0;
                        if (crc_ok) begin
                           cmd_o       <= {frame, rx_byte};
                           cmd_valid_o <= 1'b1;
                        end
`ifdef SPI_SD_CRC7_EN
                        else begin
                           crc_err_o <= 1'b1;
                           r1_have   <= 1'b1;
                           r1_byte   <= SD_R1_CRC_ERR;
                        end
`endif
                     end else begin
                        byte_cnt <= byte_cnt + 3'd1;
                     end
                  end
                  ST_WAIT: begin
                     fill_cnt <= fill_inc;
                     if (have_r1 && fill_inc >= FW'(NCR_MIN)) begin
                        tx_nxt <= r1_val;
                        state  <= ST_RESP;
                     end else if (fill_inc >= FW'(NCR_MAX)) begin
                        timeout_o <= 1'b1;
                        state     <= ST_IDLE;
                     end
                  end
                  ST_RESP: state <= ST_IDLE;
                  default: state <= ST_IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_sd_responder.sv
// Self-checking bench for spi_sd_responder: table of command frames
// driven by a behavioural SPI initiator, with a command scoreboard.
module tb_spi_sd_responder;

   localparam int HALF  = 10;
   localparam int SYNC  = 2;
   localparam int NCRMX = 8;
`ifdef SPI_SD_CRC7_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        sck, mosi, ss;
   logic        miso, miso_oe;
   logic [47:0] cmd;
   logic        cmd_valid;
   logic [7:0]  r1;
   logic        r1_valid;
   logic        busy, timeout, crc_err;

   spi_sd_responder #(
      .SYNC_STAGES (SYNC),
      .NCR_MIN     (1),
      .NCR_MAX     (NCRMX)
   ) dut (
      .spi_clk_i   (clk),
      .spi_rst_i   (rst),
      .SCK_i       (sck),
      .MOSI_i      (mosi),
      .SS_i        (ss),
      .MISO_o      (miso),
      .miso_oe_o   (miso_oe),
      .cmd_o       (cmd),
      .cmd_valid_o (cmd_valid),
      .r1_i        (r1),
      .r1_valid_i  (r1_valid),
      .busy_o      (busy),
      .timeout_o   (timeout),
      .crc_err_o   (crc_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [47:0] frame;
      int          lead;
      int          r1_after;
      logic [7:0]  r1v;
      bit          dup;
      int          nfill;
      logic [7:0]  resp;
      bit          exp_cmd;
      bit          tmo;
      bit          crc_bad;
   } vec_t;

   vec_t        vecs [6];
   int          n_checks = 0;
   int          n_errors = 0;
   int          to_cnt = 0;
   int          ce_cnt = 0;
   logic [47:0] cmd_q [$];

   task automatic check(input string name, input logic [47:0] act,
                        input logic [47:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (cmd_valid) begin
            if (cmd_q.size() == 0)
               check("unexpected cmd_valid", 48'd1, 48'd0);
            else
               check("cmd_o", cmd, cmd_q.pop_front());
         end
         if (timeout) to_cnt++;
         if (crc_err) ce_cnt++;
      end
   end

   task automatic pulse_r1(input logic [7:0] v);
      r1       = v;
      r1_valid = 1'b1;
      @(negedge clk);
      r1_valid = 1'b0;
   endtask

   task automatic xfer(input logic [7:0] tx, input bit p,
                       input logic [7:0] pv, input bit dup,
                       output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk);
         mosi = tx[i];
         if (p && i == 7) pulse_r1(pv);
         if (dup && i == 3) pulse_r1(8'h7F);
         repeat (HALF) @(negedge clk);
         sck   = 1'b1;
         rx[i] = miso;
         repeat (HALF) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [7:0] rx;
      logic [7:0] exp_q [$];
      logic [7:0] fb;
      int         to0, ce0, n;
      to0 = to_cnt;
      ce0 = ce_cnt;
      ss  = 1'b0;
      repeat (20) @(negedge clk);
      check($sformatf("v%0d miso_oe", idx), 48'(miso_oe), 48'd1);
      for (int k = 0; k < v.lead; k++) begin
         exp_q.push_back(8'hFF);
         xfer(8'hFF, 1'b0, 8'h00, 1'b0, rx);
         check($sformatf("v%0d lead%0d", idx, k), 48'(rx),
               48'(exp_q.pop_front()));
      end
      if (v.exp_cmd) cmd_q.push_back(v.frame);
      for (int b = 0; b < 6; b++) begin
         fb = v.frame[47-8*b -: 8];
         xfer(fb, 1'b0, 8'h00, 1'b0, rx);
      end
      n = v.tmo ? NCRMX : v.nfill + 1;
      for (int k = 0; k < n; k++) begin
         exp_q.push_back((v.tmo || k < v.nfill) ? 8'hFF : v.resp);
         xfer(8'hFF, k == v.r1_after, v.r1v,
              v.dup && k == v.r1_after, rx);
         check($sformatf("v%0d miso%0d", idx, k), 48'(rx),
               48'(exp_q.pop_front()));
      end
      repeat (20) @(negedge clk);
      check($sformatf("v%0d busy", idx), 48'(busy), 48'd0);
      check($sformatf("v%0d timeouts", idx), 48'(to_cnt - to0),
            48'(v.tmo));
      check($sformatf("v%0d crc_errs", idx), 48'(ce_cnt - ce0),
            48'(v.crc_bad && CRC_ON));
      ss = 1'b1;
      repeat (SYNC + 3) @(negedge clk);
      check($sformatf("v%0d oe_off", idx), 48'(miso_oe), 48'd0);
      check($sformatf("v%0d miso_idle", idx), 48'(miso), 48'd1);
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rx;
      vecs[0] = '{48'h400000000095, 0, 0, 8'h01, 1'b1, 1, 8'h01,
                  1'b1, 1'b0, 1'b0};
      vecs[1] = '{48'h48000001AA87, 0, 2, 8'h01, 1'b0, 3, 8'h01,
                  1'b1, 1'b0, 1'b0};
      vecs[2] = '{48'h5100000000FF, 2, 0, 8'h00, 1'b0, 1,
                  CRC_ON ? 8'h08 : 8'h00, !CRC_ON, 1'b0, 1'b1};
      vecs[3] = '{48'h400000000095, 0, -1, 8'h00, 1'b0, NCRMX, 8'hFF,
                  1'b1, 1'b1, 1'b0};
      vecs[4] = '{48'h770000000065, 0, 1, 8'h05, 1'b0, 2, 8'h05,
                  1'b1, 1'b0, 1'b0};
      vecs[5] = '{48'h400000000094, 0, 0, 8'h01, 1'b0, 1,
                  CRC_ON ? 8'h08 : 8'h01, !CRC_ON, 1'b0, 1'b1};

      rst = 1'b1;
      sck = 1'b0;
      mosi = 1'b1;
      ss = 1'b1;
      r1 = 8'h00;
      r1_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("rst MISO", 48'(miso), 48'd1);
      check("rst miso_oe", 48'(miso_oe), 48'd0);
      check("rst cmd_o", cmd, 48'd0);
      check("rst cmd_valid", 48'(cmd_valid), 48'd0);
      check("rst busy", 48'(busy), 48'd0);
      check("rst timeout", 48'(timeout), 48'd0);
      check("rst crc_err", 48'(crc_err), 48'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i], i);
         repeat (10) @(negedge clk);
      end

      ss = 1'b0;
      repeat (20) @(negedge clk);
      xfer(8'h40, 1'b0, 8'h00, 1'b0, rx);
      xfer(8'h00, 1'b0, 8'h00, 1'b0, rx);
      xfer(8'h00, 1'b0, 8'h00, 1'b0, rx);
      check("abort busy_before", 48'(busy), 48'd1);
      ss = 1'b1;
      repeat (SYNC + 2) @(negedge clk);
      check("abort miso_oe", 48'(miso_oe), 48'd0);
      check("abort busy", 48'(busy), 48'd0);
      repeat (10) @(negedge clk);
      run_vec(vecs[0], 10);

      repeat (20) @(negedge clk);
      check("cmd queue drained", 48'(cmd_q.size()), 48'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
